usb_command_decoder: RTL and testbench

- Host-to-device end of the USB control path. Pops 16-bit command words from the USB command FIFO and decodes them.
- Drives the registered slow-control parameters (mode select, 10-bit DACs, masks, CTest channel, SC/ReadReg select) consumed by the mode switcher.
- Sequences the SC parameter load pulse and waits for completion. Echoes each accepted word back toward the USB data FIFO path.

---
 rtl/usb_command_decoder.sv | 184 ++++++++++++++++++
 tb/tb_usb_command_decoder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_command_decoder.sv
// Host-to-device USB command decoder: pops 16-bit words from the command FIFO,
// updates the slow-control parameter registers and sequences the SC load handshake.
module usb_command_decoder #(
    parameter logic [9:0]  DAC_DEFAULT       = 10'd250,
    parameter int unsigned LOAD_PULSE_CYCLES = 4,
    parameter int unsigned DONE_TIMEOUT      = 65535
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        CommandFifoEmpty,
    input  logic [15:0] CommandFifoData,
    output logic        CommandFifoRdEn,
    output logic [1:0]  ModeSelect,
    output logic [9:0]  Microroc10bitDAC0,
    output logic [9:0]  Microroc10bitDAC1,
    output logic [9:0]  Microroc10bitDAC2,
    output logic [6:0]  MicrorocChannelMask,
    output logic [1:0]  MicrorocDiscriMask,
    output logic [6:0]  MicrorocCTestChannel,
    output logic        SC_or_Readreg,
    output logic        SCParameterLoad,
    input  logic        SCDone,
    output logic [15:0] CommandEcho,
    output logic        CommandEcho_en,
    output logic        CommandError,
    output logic        Busy
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_READ      = 3'd1;
    localparam logic [2:0] S_LATCH     = 3'd2;
    localparam logic [2:0] S_EXEC      = 3'd3;
    localparam logic [2:0] S_LOAD      = 3'd4;
    localparam logic [2:0] S_WAIT_DONE = 3'd5;

    localparam logic [15:0] LOAD_LAST = 16'(LOAD_PULSE_CYCLES - 32'd1);
    localparam logic [15:0] DONE_LAST = 16'(DONE_TIMEOUT - 32'd1);

    logic [2:0]  state_q, state_d;
    logic [15:0] word_q, word_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  mode_q, mode_d;
    logic [9:0]  dac0_q, dac0_d, dac1_q, dac1_d, dac2_q, dac2_d;
    logic [6:0]  cmask_q, cmask_d, ctest_q, ctest_d;
    logic [1:0]  dmask_q, dmask_d;
    logic        scrr_q, scrr_d;
    logic [15:0] echo_q, echo_d;
    logic        echo_en_q, echo_en_d;
    logic        err_q, err_d;
    logic        rden_q, load_q, busy_q;

    // Next-state and decode logic; strobes default low so they last one cycle.
    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        dac0_d    = dac0_q;
        dac1_d    = dac1_q;
        dac2_d    = dac2_q;
        cmask_d   = cmask_q;
        dmask_d   = dmask_q;
        ctest_d   = ctest_q;
        scrr_d    = scrr_q;
        echo_d    = echo_q;
        echo_en_d = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!CommandFifoEmpty) begin
                    state_d = S_READ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: state_d = S_LATCH;
            S_LATCH: begin
                word_d  = CommandFifoData;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d   = S_IDLE;
                cnt_d     = 16'd0;
                echo_d    = word_q;
                echo_en_d = 1'b1;
                case (word_q[15:12])
                    4'h1: mode_d = word_q[1:0];
                    4'h2: dac0_d = word_q[9:0];
                    4'h3: dac1_d = word_q[9:0];
                    4'h4: dac2_d = word_q[9:0];
                    4'h5: begin
                        cmask_d = word_q[6:0];
                        dmask_d = word_q[8:7];
                    end
                    4'h6: ctest_d = word_q[6:0];
                    4'h7: scrr_d  = word_q[0];
                    4'h8: state_d = S_LOAD;
                    default: begin
                        // Unknown opcode: flag it, keep the previous echo.
                        echo_d    = echo_q;
                        echo_en_d = 1'b0;
                        err_d     = 1'b1;
                    end
                endcase
            end
            S_LOAD: begin
                if (cnt_q == LOAD_LAST) begin
                    state_d = S_WAIT_DONE;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_WAIT_DONE: begin
                if (SCDone) begin
                    state_d = S_IDLE;
                end else if (cnt_q == DONE_LAST) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; strobes are registered from the next state.
    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            word_q    <= 16'd0;
            cnt_q     <= 16'd0;
            mode_q    <= 2'b00;
            dac0_q    <= DAC_DEFAULT;
            dac1_q    <= DAC_DEFAULT;
            dac2_q    <= DAC_DEFAULT;
            cmask_q   <= 7'd0;
            dmask_q   <= 2'd0;
            ctest_q   <= 7'd0;
            scrr_q    <= 1'b1;
            echo_q    <= 16'd0;
            echo_en_q <= 1'b0;
            err_q     <= 1'b0;
            rden_q    <= 1'b0;
            load_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            dac0_q    <= dac0_d;
            dac1_q    <= dac1_d;
            dac2_q    <= dac2_d;
            cmask_q   <= cmask_d;
            dmask_q   <= dmask_d;
            ctest_q   <= ctest_d;
            scrr_q    <= scrr_d;
            echo_q    <= echo_d;
            echo_en_q <= echo_en_d;
            err_q     <= err_d;
            rden_q    <= (state_d == S_READ);
            load_q    <= (state_d == S_LOAD);
            busy_q    <= (state_d != S_IDLE);
        end
    end

    assign CommandFifoRdEn      = rden_q;
    assign ModeSelect           = mode_q;
    assign Microroc10bitDAC0    = dac0_q;
    assign Microroc10bitDAC1    = dac1_q;
    assign Microroc10bitDAC2    = dac2_q;
    assign MicrorocChannelMask  = cmask_q;
    assign MicrorocDiscriMask   = dmask_q;
    assign MicrorocCTestChannel = ctest_q;
    assign SC_or_Readreg        = scrr_q;
    assign SCParameterLoad      = load_q;
    assign CommandEcho          = echo_q;
    assign CommandEcho_en       = echo_en_q;
    assign CommandError         = err_q;
    assign Busy                 = busy_q;

endmodule

// File: tb/tb_usb_command_decoder.sv
// Scoreboard bench for usb_command_decoder: a FIFO model feeds commands, and
// expected echoes/errors are queued at push time and retired as the DUT strobes.
module tb_usb_command_decoder;

    logic        Clk = 1'b0;
    logic        reset = 1'b1;
    logic        CommandFifoEmpty = 1'b1;
    logic [15:0] CommandFifoData = 16'd0;
    logic        CommandFifoRdEn;
    logic [1:0]  ModeSelect;
    logic [9:0]  Microroc10bitDAC0, Microroc10bitDAC1, Microroc10bitDAC2;
    logic [6:0]  MicrorocChannelMask, MicrorocCTestChannel;
    logic [1:0]  MicrorocDiscriMask;
    logic        SC_or_Readreg, SCParameterLoad;
    logic        SCDone = 1'b0;
    logic [15:0] CommandEcho;
    logic        CommandEcho_en, CommandError, Busy;

    usb_command_decoder #(
        .DAC_DEFAULT(10'd250), .LOAD_PULSE_CYCLES(4), .DONE_TIMEOUT(20)
    ) dut (
        .Clk(Clk), .reset(reset),
        .CommandFifoEmpty(CommandFifoEmpty), .CommandFifoData(CommandFifoData),
        .CommandFifoRdEn(CommandFifoRdEn), .ModeSelect(ModeSelect),
        .Microroc10bitDAC0(Microroc10bitDAC0), .Microroc10bitDAC1(Microroc10bitDAC1),
        .Microroc10bitDAC2(Microroc10bitDAC2), .MicrorocChannelMask(MicrorocChannelMask),
        .MicrorocDiscriMask(MicrorocDiscriMask), .MicrorocCTestChannel(MicrorocCTestChannel),
        .SC_or_Readreg(SC_or_Readreg), .SCParameterLoad(SCParameterLoad), .SCDone(SCDone),
        .CommandEcho(CommandEcho), .CommandEcho_en(CommandEcho_en),
        .CommandError(CommandError), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        is_err;
        logic        chk_lat;
        logic [15:0] word;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] fifo[$];
    int          rden_cyc[$];
    int          cyc = 0;
    int          last_rden = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    logic [1:0]  m_mode;
    logic [9:0]  m_dac0, m_dac1, m_dac2;
    logic [6:0]  m_cmask, m_ctest;
    logic [1:0]  m_dmask;
    logic        m_scrr;
    logic [15:0] m_echo;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        m_mode = 2'b00; m_dac0 = 10'd250; m_dac1 = 10'd250; m_dac2 = 10'd250;
        m_cmask = 7'd0; m_dmask = 2'd0; m_ctest = 7'd0; m_scrr = 1'b1; m_echo = 16'd0;
    endfunction

    function automatic void model_apply(input logic [15:0] w);
        case (w[15:12])
            4'h1: m_mode = w[1:0];
            4'h2: m_dac0 = w[9:0];
            4'h3: m_dac1 = w[9:0];
            4'h4: m_dac2 = w[9:0];
            4'h5: begin m_cmask = w[6:0]; m_dmask = w[8:7]; end
            4'h6: m_ctest = w[6:0];
            4'h7: m_scrr = w[0];
            default: ;
        endcase
        m_echo = w;
    endfunction

    task automatic check_model();
        check("mode",  32'(ModeSelect), 32'(m_mode));
        check("dac0",  32'(Microroc10bitDAC0), 32'(m_dac0));
        check("dac1",  32'(Microroc10bitDAC1), 32'(m_dac1));
        check("dac2",  32'(Microroc10bitDAC2), 32'(m_dac2));
        check("cmask", 32'(MicrorocChannelMask), 32'(m_cmask));
        check("dmask", 32'(MicrorocDiscriMask), 32'(m_dmask));
        check("ctest", 32'(MicrorocCTestChannel), 32'(m_ctest));
        check("scrr",  32'(SC_or_Readreg), 32'(m_scrr));
        check("echo",  32'(CommandEcho), 32'(m_echo));
    endtask

    task automatic check_reset_vals();
        check("rst_mode", 32'(ModeSelect), 32'd0);
        check("rst_dac0", 32'(Microroc10bitDAC0), 32'd250);
        check("rst_dac1", 32'(Microroc10bitDAC1), 32'd250);
        check("rst_dac2", 32'(Microroc10bitDAC2), 32'd250);
        check("rst_masks", 32'({MicrorocDiscriMask, MicrorocChannelMask}), 32'd0);
        check("rst_ctest", 32'(MicrorocCTestChannel), 32'd0);
        check("rst_scrr", 32'(SC_or_Readreg), 32'd1);
        check("rst_strobes", 32'({CommandFifoRdEn, SCParameterLoad, CommandEcho_en, CommandError}), 32'd0);
        check("rst_echo", 32'(CommandEcho), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
    endtask

    task automatic push_cmd(input logic [15:0] w);
        exp_t e;
        e.word    = w;
        e.is_err  = (w[15:12] == 4'h0) || (w[15:12] > 4'h8);
        e.chk_lat = 1'b1;
        fifo.push_back(w);
        sb.push_back(e);
    endtask

    task automatic push_timeout();
        exp_t e;
        e.word = 16'd0; e.is_err = 1'b1; e.chk_lat = 1'b0;
        sb.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || fifo.size() != 0) && n < 300) begin
            @(negedge Clk); n++;
        end
        check("drain_pending", 32'(sb.size() + fifo.size()), 32'd0);
        repeat (2) @(negedge Clk);
    endtask

    task automatic wait_load(input logic level, input string tag);
        int n = 0;
        while (SCParameterLoad !== level && n < 100) begin
            @(negedge Clk); n++;
        end
        check(tag, 32'(SCParameterLoad), 32'(level));
    endtask

    // FIFO model and scoreboard retirement, sampled mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            cyc++;
            if (CommandFifoRdEn) begin
                check("rden_nonempty", 32'(fifo.size() != 0), 32'd1);
                if (fifo.size() != 0) CommandFifoData = fifo.pop_front();
                rden_cyc.push_back(cyc);
                last_rden = cyc;
            end
            CommandFifoEmpty = (fifo.size() == 0);
            if (CommandEcho_en || CommandError) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected", 32'({CommandEcho_en, CommandError}), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("sb_err", 32'(CommandError), 32'(e.is_err));
                    check("sb_echo_en", 32'(CommandEcho_en), 32'(!e.is_err));
                    if (e.chk_lat) check("latency", 32'(cyc - last_rden), 32'd3);
                    if (!e.is_err) model_apply(e.word);
                    check_model();
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int len, n;
        model_reset();
        repeat (3) @(negedge Clk);
        reset = 1'b0;
        check_reset_vals();

        // Single DAC0 write.
        push_cmd(16'h2155);
        drain();
        check("dac0_0x155", 32'(Microroc10bitDAC0), 32'h155);
        check("rden_single", 32'(rden_cyc.size()), 32'd1);

        // Back-to-back commands must be read exactly 4 cycles apart.
        rden_cyc.delete();
        push_cmd(16'h1001); push_cmd(16'h5185); push_cmd(16'h6003);
        drain();
        check("b2b_count", 32'(rden_cyc.size()), 32'd3);
        if (rden_cyc.size() == 3) begin
            check("b2b_gap1", 32'(rden_cyc[1] - rden_cyc[0]), 32'd4);
            check("b2b_gap2", 32'(rden_cyc[2] - rden_cyc[1]), 32'd4);
        end
        check("b2b_mode", 32'(ModeSelect), 32'd1);
        check("b2b_cmask", 32'(MicrorocChannelMask), 32'h05);
        check("b2b_dmask", 32'(MicrorocDiscriMask), 32'd3);
        check("b2b_ctest", 32'(MicrorocCTestChannel), 32'd3);

        // Load with SCDone; the queued DAC write must wait for completion.
        push_cmd(16'h8000); push_cmd(16'h2001);
        wait_load(1'b1, "load_rise");
        len = 0;
        while (SCParameterLoad && len < 20) begin
            check("load_busy", 32'(Busy), 32'd1);
            check("load_no_rden", 32'(CommandFifoRdEn), 32'd0);
            len++;
            @(negedge Clk);
        end
        check("load_len", 32'(len), 32'd4);
        repeat (9) begin
            check("wait_busy", 32'(Busy), 32'd1);
            check("wait_no_rden", 32'(CommandFifoRdEn), 32'd0);
            @(negedge Clk);
        end
        SCDone = 1'b1;
        check("done_no_rden", 32'(CommandFifoRdEn), 32'd0);
        @(negedge Clk);
        SCDone = 1'b0;
        check("done_idle", 32'(Busy), 32'd0);
        n = 0;
        while (!CommandFifoRdEn && n < 5) begin
            @(negedge Clk); n++;
        end
        check("rden_after_done", 32'(n), 32'd1);
        drain();
        check("dac0_after_load", 32'(Microroc10bitDAC0), 32'h001);

        // Load timeout, then an illegal opcode.
        push_cmd(16'h8000); push_timeout();
        wait_load(1'b1, "to_load_rise");
        wait_load(1'b0, "to_load_fall");
        n = 0;
        while (!CommandError && n < 40) begin
            @(negedge Clk); n++;
        end
        check("timeout_cycles", 32'(n), 32'd20);
        check("timeout_idle", 32'(Busy), 32'd0);
        drain();
        push_cmd(16'hF123);
        drain();
        check("bad_op_echo", 32'(CommandEcho), 32'h8000);

        // Reset during WAIT_DONE, then a late SCDone.
        push_cmd(16'h8000);
        wait_load(1'b1, "rst_load_rise");
        wait_load(1'b0, "rst_load_fall");
        repeat (3) @(negedge Clk);
        reset = 1'b1;
        @(negedge Clk);
        reset = 1'b0;
        model_reset();
        check_reset_vals();
        sb.delete();
        rden_cyc.delete();
        SCDone = 1'b1;
        @(negedge Clk);
        SCDone = 1'b0;
        repeat (5) @(negedge Clk);
        check_reset_vals();
        check("late_done_no_rden", 32'(rden_cyc.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
